// File: rtl/axil_reg_bank.sv
// AXI4-Lite register bank: version word, RW control regs, RO status words.
// Optional define AXIL_WR_PULSE_EN adds a per-register write strobe output.
module axil_reg_bank #(
    parameter int                   ADDR_W   = 12,
    parameter int                   NUM_RW   = 8,
    parameter int                   NUM_RO   = 4,
    parameter logic [31:0]          VERSION  = 32'h2022_1024,
    parameter logic [NUM_RW*32-1:0] CTRL_RST = '0
) (
    input  logic                   sys_clk,
    input  logic                   pl_rst_n,
    input  logic [ADDR_W-1:0]      s_axil_awaddr,
    input  logic [2:0]             s_axil_awprot,
    input  logic                   s_axil_awvalid,
    output logic                   s_axil_awready,
    input  logic [31:0]            s_axil_wdata,
    input  logic [3:0]             s_axil_wstrb,
    input  logic                   s_axil_wvalid,
    output logic                   s_axil_wready,
    output logic [1:0]             s_axil_bresp,
    output logic                   s_axil_bvalid,
    input  logic                   s_axil_bready,
    input  logic [ADDR_W-1:0]      s_axil_araddr,
    input  logic [2:0]             s_axil_arprot,
    input  logic                   s_axil_arvalid,
    output logic                   s_axil_arready,
    output logic [31:0]            s_axil_rdata,
    output logic [1:0]             s_axil_rresp,
    output logic                   s_axil_rvalid,
    input  logic                   s_axil_rready,
    output logic [NUM_RW*32-1:0]   ctrl_o,
`ifdef AXIL_WR_PULSE_EN
    output logic [NUM_RW-1:0]      ctrl_wr_pulse_o,
`endif
    input  logic [NUM_RO*32-1:0]   status_i
);

    localparam int IW = ADDR_W - 2;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {T_VER, T_RW, T_RO, T_NONE} tgt_e;

    function automatic tgt_e classify(input logic [IW-1:0] idx);
        if (idx == '0) return T_VER;
        if (idx <= IW'(NUM_RW)) return T_RW;
        if (idx <= IW'(NUM_RW + NUM_RO)) return T_RO;
        return T_NONE;
    endfunction

    logic              run_q;
    logic              aw_held;
    logic              w_held;
    logic [IW-1:0]     aw_idx_q;
    logic [31:0]       w_data_q;
    logic [3:0]        w_strb_q;
    logic [31:0]       ctrl_q [NUM_RW];

    logic [IW-1:0]     ar_idx;
    tgt_e              rd_tgt;
    tgt_e              wr_tgt;
    logic [31:0]       rd_data;
    logic [1:0]        rd_resp;
    logic              commit;
    logic              unused_bits;

    assign unused_bits = ^{s_axil_awprot, s_axil_arprot,
                           s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    // Readies are gated by run_q so they rise on the first edge after reset.
    assign s_axil_awready = run_q & ~aw_held & ~s_axil_bvalid;
    assign s_axil_wready  = run_q & ~w_held & ~s_axil_bvalid;
    assign s_axil_arready = run_q & ~s_axil_rvalid;

    assign commit = aw_held & w_held;
    assign wr_tgt = classify(aw_idx_q);
    assign ar_idx = s_axil_araddr[ADDR_W-1:2];
    assign rd_tgt = classify(ar_idx);

    for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrl
        assign ctrl_o[32*g +: 32] = ctrl_q[g];
    end

    always_comb begin
        rd_data = '0;
        rd_resp = OKAY;
        unique case (rd_tgt)
            T_VER: rd_data = VERSION;
            T_RW: begin
                for (int k = 0; k < NUM_RW; k++)
                    if (ar_idx == IW'(k + 1)) rd_data = ctrl_q[k];
            end
            T_RO: begin
                for (int k = 0; k < NUM_RO; k++)
                    if (ar_idx == IW'(NUM_RW + 1 + k))
                        rd_data = status_i[32*k +: 32];
            end
            default: rd_resp = SLVERR;
        endcase
    end

    always_ff @(posedge sys_clk or negedge pl_rst_n) begin
        if (!pl_rst_n) begin
            run_q         <= 1'b0;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_idx_q      <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= OKAY;
            s_axil_rvalid <= 1'b0;
            s_axil_rresp  <= OKAY;
            s_axil_rdata  <= '0;
            for (int k = 0; k < NUM_RW; k++)
                ctrl_q[k] <= CTRL_RST[32*k +: 32];
        end else begin
            run_q <= 1'b1;
            if (s_axil_awvalid && s_axil_awready) begin
                aw_held  <= 1'b1;
                aw_idx_q <= s_axil_awaddr[ADDR_W-1:2];
            end
            if (s_axil_wvalid && s_axil_wready) begin
                w_held   <= 1'b1;
                w_data_q <= s_axil_wdata;
                w_strb_q <= s_axil_wstrb;
            end
            if (commit) begin
                aw_held       <= 1'b0;
                w_held        <= 1'b0;
                s_axil_bvalid <= 1'b1;
                s_axil_bresp  <= (wr_tgt == T_RW) ? OKAY : SLVERR;
                for (int k = 0; k < NUM_RW; k++) begin
                    if (wr_tgt == T_RW && aw_idx_q == IW'(k + 1)) begin
                        for (int b = 0; b < 4; b++)
                            if (w_strb_q[b])
                                ctrl_q[k][8*b +: 8] <= w_data_q[8*b +: 8];
                    end
                end
            end else if (s_axil_bvalid && s_axil_bready) begin
                s_axil_bvalid <= 1'b0;
            end
            // Capture uses pre-commit register state, so a racing read sees old data.
            if (s_axil_arvalid && s_axil_arready) begin
                s_axil_rvalid <= 1'b1;
                s_axil_rdata  <= rd_data;
                s_axil_rresp  <= rd_resp;
            end else if (s_axil_rvalid && s_axil_rready) begin
                s_axil_rvalid <= 1'b0;
            end
        end
    end

`ifdef AXIL_WR_PULSE_EN
    always_ff @(posedge sys_clk or negedge pl_rst_n) begin
        if (!pl_rst_n) begin
            ctrl_wr_pulse_o <= '0;
        end else begin
            ctrl_wr_pulse_o <= '0;
            if (commit && wr_tgt == T_RW) begin
                for (int k = 0; k < NUM_RW; k++)
                    if (aw_idx_q == IW'(k + 1)) ctrl_wr_pulse_o[k] <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axil_reg_bank.sv
// Testbench for axil_reg_bank: directed scenarios plus randomized
// traffic checked against an array-based register model.
module tb_axil_reg_bank;

    localparam int NRW = 8;
    localparam int NRO = 4;
    localparam logic [31:0] VER = 32'h2022_1024;

    logic           clk = 0;
    logic           rst_n = 0;
    logic [11:0]    awaddr = '0;
    logic [2:0]     awprot = '0;
    logic           awvalid = 0;
    logic           awready;
    logic [31:0]    wdata = '0;
    logic [3:0]     wstrb = '0;
    logic           wvalid = 0;
    logic           wready;
    logic [1:0]     bresp;
    logic           bvalid;
    logic           bready = 1;
    logic [11:0]    araddr = '0;
    logic [2:0]     arprot = '0;
    logic           arvalid = 0;
    logic           arready;
    logic [31:0]    rdata;
    logic [1:0]     rresp;
    logic           rvalid;
    logic           rready = 1;
    logic [NRW*32-1:0] ctrl;
    logic [NRO*32-1:0] status = '0;
`ifdef AXIL_WR_PULSE_EN
    logic [NRW-1:0] pulse;
`endif

    int checks = 0;
    int failures = 0;
    logic [31:0] mdl [NRW];

    axil_reg_bank dut (
        .sys_clk        (clk),
        .pl_rst_n       (rst_n),
        .s_axil_awaddr  (awaddr),
        .s_axil_awprot  (awprot),
        .s_axil_awvalid (awvalid),
        .s_axil_awready (awready),
        .s_axil_wdata   (wdata),
        .s_axil_wstrb   (wstrb),
        .s_axil_wvalid  (wvalid),
        .s_axil_wready  (wready),
        .s_axil_bresp   (bresp),
        .s_axil_bvalid  (bvalid),
        .s_axil_bready  (bready),
        .s_axil_araddr  (araddr),
        .s_axil_arprot  (arprot),
        .s_axil_arvalid (arvalid),
        .s_axil_arready (arready),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .s_axil_rvalid  (rvalid),
        .s_axil_rready  (rready),
        .ctrl_o         (ctrl),
`ifdef AXIL_WR_PULSE_EN
        .ctrl_wr_pulse_o(pulse),
`endif
        .status_i       (status)
    );

    always #5 clk = ~clk;

    function automatic logic [NRW*32-1:0] mdl_flat();
        logic [NRW*32-1:0] f;
        for (int k = 0; k < NRW; k++) f[32*k +: 32] = mdl[k];
        return f;
    endfunction

    function automatic void mdl_write(input int idx, input logic [31:0] d,
                                      input logic [3:0] s,
                                      output logic [1:0] r);
        r = 2'b10;
        if (idx >= 1 && idx <= NRW) begin
            r = 2'b00;
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[idx-1][8*b +: 8] = d[8*b +: 8];
        end
    endfunction

    function automatic void mdl_read(input int idx,
                                     input logic [NRO*32-1:0] st,
                                     output logic [31:0] d,
                                     output logic [1:0] r);
        d = '0;
        r = 2'b00;
        if (idx == 0) d = VER;
        else if (idx <= NRW) d = mdl[idx-1];
        else if (idx <= NRW + NRO) d = st[32*(idx-NRW-1) +: 32];
        else r = 2'b10;
    endfunction

    task automatic do_write(input logic [11:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly,
                            input int w_dly, output logic [1:0] resp,
                            output logic [NRW*32-1:0] ctrl_at_b,
                            output int lat, output bit ok);
        bit aw_done, w_done, hs_aw, hs_w;
        int n;
        aw_done = 0; w_done = 0; n = 0; ok = 1; lat = 0;
        resp = 2'bxx; ctrl_at_b = '0;
        bready = 1;
        while (!(aw_done && w_done) && ok) begin
            @(negedge clk);
            awvalid = !aw_done && n >= aw_dly;
            awaddr = addr;
            wvalid = !w_done && n >= w_dly;
            wdata = data;
            wstrb = strb;
            hs_aw = awvalid && awready;
            hs_w = wvalid && wready;
            @(posedge clk);
            if (hs_aw) aw_done = 1;
            if (hs_w) w_done = 1;
            n++;
            if (n > 60) ok = 0;
        end
        @(negedge clk);
        awvalid = 0;
        wvalid = 0;
        lat = 1;
        while (!bvalid && ok) begin
            @(negedge clk);
            lat++;
            if (lat > 30) ok = 0;
        end
        if (ok) begin
            resp = bresp;
            ctrl_at_b = ctrl;
            @(posedge clk);
        end
    endtask

    task automatic do_read(input logic [11:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output bit ok);
        int n;
        bit hs;
        n = 0; ok = 1; hs = 0;
        rready = 1;
        while (!hs && ok) begin
            @(negedge clk);
            arvalid = 1;
            araddr = addr;
            hs = arready;
            @(posedge clk);
            n++;
            if (n > 60) ok = 0;
        end
        @(negedge clk);
        arvalid = 0;
        if (!rvalid) ok = 0;
        data = rdata;
        resp = rresp;
    endtask

    task automatic test_reset();
        rst_n = 0;
        for (int k = 0; k < NRW; k++) mdl[k] = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 ||
            rdata !== 32'h0 || bresp !== 2'b00 || rresp !== 2'b00 ||
            ctrl !== mdl_flat()) begin
            failures++;
            $display("FAIL reset_state: rdy/valid=%b rdata=%h ctrl=%h",
                     {awready, wready, arready, bvalid, rvalid}, rdata, ctrl);
        end
        rst_n = 1;
        @(negedge clk);
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            failures++;
            $display("FAIL ready_after_reset: got %b want 111",
                     {awready, wready, arready});
        end
    endtask

    task automatic test_basic_read();
        logic [31:0] d; logic [1:0] r; bit ok;
        do_read(12'h000, d, r, ok);
        checks++;
        if (!ok || d !== VER || r !== 2'b00) begin
            failures++;
            $display("FAIL read_version: ok=%0d rdata=%h rresp=%b want %h 00",
                     ok, d, r, VER);
        end
        do_read(12'h004, d, r, ok);
        checks++;
        if (!ok || d !== 32'h0 || r !== 2'b00) begin
            failures++;
            $display("FAIL read_ctrl0_rst: ok=%0d rdata=%h rresp=%b want 0 00",
                     ok, d, r);
        end
    endtask

    task automatic test_split_write();
        logic [1:0] r, er; logic [NRW*32-1:0] c; int lat; bit ok;
        logic [31:0] d;
        do_write(12'h008, 32'hA5A5_1234, 4'hF, 0, 3, r, c, lat, ok);
        mdl_write(2, 32'hA5A5_1234, 4'hF, er);
        checks++;
        if (!ok || r !== 2'b00 || c[63:32] !== 32'hA5A5_1234 || lat != 2) begin
            failures++;
            $display("FAIL split_write: ok=%0d bresp=%b ctrl1=%h lat=%0d want 00 A5A51234 2",
                     ok, r, c[63:32], lat);
        end
        do_read(12'h008, d, r, ok);
        checks++;
        if (!ok || d !== 32'hA5A5_1234 || r !== 2'b00) begin
            failures++;
            $display("FAIL split_readback: rdata=%h rresp=%b want A5A51234 00", d, r);
        end
    endtask

    task automatic test_strobe();
        logic [1:0] r, er; logic [NRW*32-1:0] c; int lat; bit ok;
        do_write(12'h008, 32'hFFFF_FFFF, 4'b0101, 2, 0, r, c, lat, ok);
        mdl_write(2, 32'hFFFF_FFFF, 4'b0101, er);
        checks++;
        if (!ok || r !== 2'b00 || c[63:32] !== 32'hA5FF_12FF) begin
            failures++;
            $display("FAIL strobe_write: bresp=%b ctrl1=%h want 00 A5FF12FF",
                     r, c[63:32]);
        end
    endtask

    task automatic test_slverr();
        logic [1:0] r; logic [NRW*32-1:0] c; int lat; bit ok;
        logic [31:0] d;
        do_write(12'h028, 32'h1111_2222, 4'hF, 0, 0, r, c, lat, ok);
        checks++;
        if (!ok || r !== 2'b10 || c !== mdl_flat()) begin
            failures++;
            $display("FAIL write_ro: bresp=%b want 10 ctrl=%h", r, c);
        end
        do_write(12'h400, 32'h3333_4444, 4'hF, 1, 0, r, c, lat, ok);
        checks++;
        if (!ok || r !== 2'b10 || c !== mdl_flat()) begin
            failures++;
            $display("FAIL write_unmapped: bresp=%b want 10 ctrl=%h", r, c);
        end
        do_write(12'h000, 32'h5555_6666, 4'hF, 0, 1, r, c, lat, ok);
        checks++;
        if (!ok || r !== 2'b10 || c !== mdl_flat()) begin
            failures++;
            $display("FAIL write_version: bresp=%b want 10", r);
        end
        do_read(12'h400, d, r, ok);
        checks++;
        if (!ok || d !== 32'h0 || r !== 2'b10) begin
            failures++;
            $display("FAIL read_unmapped: rdata=%h rresp=%b want 0 10", d, r);
        end
        status[31:0] = 32'hCAFE_0001;
        do_read(12'h024, d, r, ok);
        checks++;
        if (!ok || d !== 32'hCAFE_0001 || r !== 2'b00) begin
            failures++;
            $display("FAIL read_status0: rdata=%h rresp=%b want CAFE0001 00", d, r);
        end
    endtask

    task automatic test_stall();
        logic [31:0] nd, exp_r;
        logic [1:0] er;
        nd = $urandom;
        exp_r = mdl[0];
        @(negedge clk);
        bready = 0; rready = 0;
        awvalid = 1; awaddr = 12'h00C;
        wvalid = 1; wdata = nd; wstrb = 4'hF;
        arvalid = 1; araddr = 12'h004;
        @(posedge clk);
        @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        mdl_write(3, nd, 4'hF, er);
        @(negedge clk);
        awvalid = 1; awaddr = 12'h010; wdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bvalid !== 1 || rvalid !== 1 || rdata !== exp_r ||
                bresp !== 2'b00 || awready !== 0 || wready !== 0 ||
                arready !== 0) begin
                failures++;
                $display("FAIL stall_cycle%0d: bv=%b rv=%b rdata=%h want %h rdy=%b",
                         i, bvalid, rvalid, rdata, exp_r,
                         {awready, wready, arready});
            end
            @(negedge clk);
        end
        awvalid = 0;
        bready = 1; rready = 1;
        @(negedge clk);
        checks++;
        if (bvalid !== 0 || rvalid !== 0 || ctrl !== mdl_flat()) begin
            failures++;
            $display("FAIL stall_release: bv=%b rv=%b ctrl=%h want %h",
                     bvalid, rvalid, ctrl, mdl_flat());
        end
    endtask

    task automatic test_concurrent();
        logic [31:0] a, b, d;
        logic [1:0] r, er; logic [NRW*32-1:0] c; int lat; bit ok;
        a = $urandom; b = ~a;
        do_write(12'h010, a, 4'hF, 0, 0, r, c, lat, ok);
        mdl_write(4, a, 4'hF, er);
        @(negedge clk);
        awvalid = 1; awaddr = 12'h010;
        wvalid = 1; wdata = b; wstrb = 4'hF;
        bready = 1; rready = 1;
        @(posedge clk);
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        arvalid = 1; araddr = 12'h010;
        @(posedge clk);
        @(negedge clk);
        arvalid = 0;
        checks++;
        if (rvalid !== 1 || rdata !== a || bvalid !== 1 || ctrl[127:96] !== b) begin
            failures++;
            $display("FAIL concurrent_old: rv=%b rdata=%h want %h bv=%b ctrl3=%h want %h",
                     rvalid, rdata, a, bvalid, ctrl[127:96], b);
        end
        mdl_write(4, b, 4'hF, er);
        @(negedge clk);
        do_read(12'h010, d, r, ok);
        checks++;
        if (!ok || d !== b) begin
            failures++;
            $display("FAIL concurrent_new: rdata=%h want %h", d, b);
        end
    endtask

    task automatic test_random();
        int idx, op;
        logic [11:0] addr;
        logic [31:0] d, ed;
        logic [1:0] r, er;
        logic [NRW*32-1:0] c;
        int lat;
        bit ok;
        for (int i = 0; i < 80; i++) begin
            idx = $urandom_range(0, NRW + NRO + 3);
            if ($urandom_range(0, 7) == 0) idx = $urandom_range(14, 1023);
            addr = {idx[9:0], 2'($urandom_range(0, 3))};
            op = $urandom_range(0, 1);
            if (op == 0) begin
                d = $urandom;
                do_write(addr, d, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3),
                         r, c, lat, ok);
                mdl_write(idx, d, wstrb, er);
                checks++;
                if (!ok || r !== er || c !== mdl_flat() || lat != 2) begin
                    failures++;
                    $display("FAIL rand_write%0d: addr=%h bresp=%b want %b lat=%0d ctrl=%h want %h",
                             i, addr, r, er, lat, c, mdl_flat());
                end
            end else begin
                status = {$urandom, $urandom, $urandom, $urandom};
                mdl_read(idx, status, ed, er);
                do_read(addr, d, r, ok);
                checks++;
                if (!ok || d !== ed || r !== er) begin
                    failures++;
                    $display("FAIL rand_read%0d: addr=%h rdata=%h rresp=%b want %h %b",
                             i, addr, d, r, ed, er);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic [1:0] r; bit ok;
        @(negedge clk);
        awvalid = 1; awaddr = 12'h008; wvalid = 0; bready = 1;
        @(posedge clk);
        @(negedge clk);
        awvalid = 0;
        #1 rst_n = 0;
        #1;
        for (int k = 0; k < NRW; k++) mdl[k] = '0;
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 ||
            ctrl !== mdl_flat()) begin
            failures++;
            $display("FAIL reset_mid: rdy/valid=%b ctrl=%h want 0",
                     {awready, wready, arready, bvalid, rvalid}, ctrl);
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        wvalid = 1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            wvalid = 0;
            checks++;
            if (bvalid !== 0 || ctrl !== mdl_flat()) begin
                failures++;
                $display("FAIL w_alone_cycle%0d: bvalid=%b ctrl=%h want 0",
                         i, bvalid, ctrl);
            end
        end
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        do_read(12'h008, d, r, ok);
        checks++;
        if (!ok || d !== 32'h0 || r !== 2'b00) begin
            failures++;
            $display("FAIL post_reset_read: rdata=%h rresp=%b want 0 00", d, r);
        end
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_split_write();
        test_strobe();
        test_slverr();
        test_stall();
        test_concurrent();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
